grade_reporter: RTL and testbench
=================================

GRADE_REPORTER -- requirements
Module: grade_reporter

Interface
REQ-001 Parameter MAX_GRADES, default 8, meaning: number of grade storage slots.
REQ-002 Parameter GRADE_W, default 8, meaning: width of one grade.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 startReport  input  1  request to read out and summarise stored grades; sampled only in IDLE.
REQ-006 gradeCount  input  4  number of valid stored grades; values above MAX_GRADES are treated as MAX_GRADES.
REQ-007 rdEn  output  1  storage read strobe; one cycle per address.
REQ-008 rdAddr  output  3  storage slot index.
REQ-009 rdData  input  GRADE_W  storage read data, valid exactly one cycle after rdEn.
REQ-010 gradeOut  output  GRADE_W  grade currently presented downstream.
REQ-011 gradeValid  output  1  gradeOut is valid.
REQ-012 gradeReady  input  1  downstream accepts gradeOut when gradeValid and gradeReady are both high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the summary outputs become final.
REQ-015 minGrade, maxGrade, avgGrade  output  GRADE_W each  summary statistics.
REQ-016 sumGrades  output  11  sum of reported grades.
REQ-017 emptyFlag  output  1  last report covered zero grades.
REQ-018 rangeErr  output  1  last report contained a grade above 100.

Function
REQ-019 The FSM SHALL have states IDLE, READ, WAIT, PRESENT, DIVIDE, and FINISH.
REQ-020 IDLE with startReport=1 SHALL clear all statistics, latch the clamped count N, set the index to 0, and go to READ; if N=0, it SHALL go to FINISH instead.
REQ-021 READ SHALL assert rdEn=1 with rdAddr equal to the index for exactly one cycle, then go to WAIT.
REQ-022 WAIT SHALL register rdData into gradeOut and update min, max, sum, and rangeErr, then go to PRESENT.
REQ-023 PRESENT SHALL hold gradeValid=1 with a stable gradeOut until gradeReady=1. On acceptance it SHALL increment the index and go to READ, or to DIVIDE once N grades have been accepted.
REQ-024 The latency from the startReport sample to the first gradeValid SHALL be 3 cycles; each additional grade with gradeReady held high SHALL cost 3 cycles.
REQ-025 min SHALL be initialised to all-ones and max to 0 at start; comparisons SHALL be unsigned.
REQ-026 The sum SHALL be an 11-bit unsigned value with no overflow: 8 × 255 = 2040 < 2048.
REQ-027 DIVIDE SHALL compute avgGrade = floor(sum / N) with an iterative shift-subtract divider taking exactly 11 cycles, then go to FINISH.
REQ-028 FINISH SHALL pulse done=1 for one cycle, publish all statistics, and return to IDLE.
REQ-029 When N=0, FINISH SHALL publish min=max=avg=sum=0 and emptyFlag=1, with done arriving 2 cycles after the start sample.
REQ-030 Statistics outputs SHALL hold their values from FINISH until the next accepted startReport.
REQ-031 startReport SHALL be ignored while busy=1.
REQ-032 gradeValid SHALL never be high outside PRESENT, and rdEn SHALL never be high outside READ.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, with rdEn, gradeValid, busy, done, emptyFlag, and rangeErr all 0, and with gradeOut, rdAddr, min, max, avg, and sum all 0.
REQ-034 Reset asserted mid-report SHALL abandon the report, and no done pulse SHALL follow.
REQ-035 The first startReport after reset release SHALL start a complete report.

Structure
REQ-036 Package grade_pkg SHALL hold the state enum, MAX_GRADES, GRADE_W, SUM_W=11, and GRADE_LIMIT=100.
REQ-037 The divider SHALL be the sub-module grade_divider, with ports start, dividend[10:0], divisor[3:0], quotient[7:0], and ready, and a fixed 11-cycle iterative implementation.
REQ-038 All outputs SHALL be registered.

Verification
REQ-039 Storage {56, 75, 100} with gradeCount=3 and gradeReady held at 1 SHALL produce gradeOut 56, 75, 100 in order, then sum=231, min=56, max=100, avg=77, rangeErr=0, and one done pulse.
REQ-040 gradeCount=0 with a start SHALL produce no rdEn, and done 2 cycles later with emptyFlag=1 and all statistics 0.
REQ-041 With gradeReady held low for 3 cycles on the second grade, gradeOut SHALL stay stable, rdEn SHALL stay low, and the final statistics SHALL be unchanged.
REQ-042 Storage with 8 slots of 255 and gradeCount=12 SHALL be clamped to 8 reads, giving sum=2040, avg=255, min=max=255, rangeErr=1.
REQ-043 A startReport pulsed while busy SHALL be ignored, giving exactly one done pulse.
REQ-044 rst_n pulsed low during PRESENT of grade 2 SHALL drive every output to 0 asynchronously with no done pulse, and a following start SHALL report correctly.

Source files
------------

// File: rtl/grade_pkg.sv
// ---------------------------------------------------------------------------
// grade_pkg
// Shared constants and the controller state encoding for the grade reporter.
//   MAX_GRADES  : number of grade storage slots
//   GRADE_W     : width of one grade
//   SUM_W       : width of the running sum (8 x 255 = 2040 fits in 11 bits)
//   GRADE_LIMIT : largest grade that is not flagged as out of range
//   state_t     : controller states
// ---------------------------------------------------------------------------
package grade_pkg;

  localparam int MAX_GRADES  = 8;
  localparam int GRADE_W     = 8;
  localparam int SUM_W       = 11;
  localparam int GRADE_LIMIT = 100;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    PRESENT,
    DIVIDE,
    FINISH
  } state_t;

endpackage : grade_pkg

// File: rtl/grade_divider.sv
// ---------------------------------------------------------------------------
// grade_divider
// Restoring shift-subtract divider, one quotient bit per cycle, 11 cycles.
// The first step is taken on the start edge directly from the dividend and
// divisor inputs, so ready rises 10 edges after start and the caller can
// leave its divide state after exactly 11 cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse; dividend/divisor must be valid on that edge
//                and remain stable while the division runs
//   dividend   : 11-bit unsigned dividend
//   divisor    : 4-bit unsigned divisor, 1..8
//   quotient   : low 8 bits of floor(dividend / divisor), valid with ready
//   ready      : high once the quotient is final, until the next start
// ---------------------------------------------------------------------------
module grade_divider
  import grade_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [3:0]       divisor,
  output logic [7:0]       quotient,
  output logic             ready
);

  logic [3:0]       rem;
  logic [SUM_W-1:0] quo;
  logic [3:0]       cnt;
  logic             running;

  logic [3:0]       rem_src;
  logic [SUM_W-1:0] quo_src;
  logic [4:0]       trial;
  logic [3:0]       rem_step;
  logic [SUM_W-1:0] quo_step;

  // One restoring step. The remainder stays below the divisor (<= 8), so the
  // shifted trial value never exceeds 15 and fits in 5 bits.
  always_comb begin
    rem_src  = start ? 4'd0 : rem;
    quo_src  = start ? dividend : quo;
    trial    = {rem_src, quo_src[SUM_W-1]};
    rem_step = trial[3:0];
    quo_step = {quo_src[SUM_W-2:0], 1'b0};
    if (trial >= {1'b0, divisor}) begin
      rem_step    = 4'(trial - {1'b0, divisor});
      quo_step[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      ready   <= 1'b0;
    end else if (start) begin
      rem     <= rem_step;
      quo     <= quo_step;
      cnt     <= 4'd10;
      running <= 1'b1;
      ready   <= 1'b0;
    end else if (running) begin
      rem <= rem_step;
      quo <= quo_step;
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        running <= 1'b0;
        ready   <= 1'b1;
      end
    end
  end

  assign quotient = quo[7:0];

endmodule : grade_divider

// File: rtl/grade_reporter.sv
// ---------------------------------------------------------------------------
// grade_reporter
// Reads up to MAX_GRADES stored grades one at a time, hands each one to a
// downstream consumer with a valid/ready handshake, and summarises them
// (min, max, sum, floor average, out-of-range flag). Every output is a flop.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   startReport         : start request, honoured only in IDLE
//   gradeCount          : number of stored grades (clamped to MAX_GRADES)
//   rdEn, rdAddr        : storage read strobe and slot index
//   rdData              : storage data, valid one cycle after rdEn
//   gradeOut/gradeValid : grade presented downstream
//   gradeReady          : downstream accept
//   busy, done          : not-IDLE indicator, one-cycle completion pulse
//   minGrade, maxGrade, avgGrade, sumGrades, emptyFlag, rangeErr : summary
// ---------------------------------------------------------------------------
module grade_reporter #(
  parameter int MAX_GRADES = 8,
  parameter int GRADE_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               startReport,
  input  logic [3:0]         gradeCount,
  output logic               rdEn,
  output logic [2:0]         rdAddr,
  input  logic [GRADE_W-1:0] rdData,
  output logic [GRADE_W-1:0] gradeOut,
  output logic               gradeValid,
  input  logic               gradeReady,
  output logic               busy,
  output logic               done,
  output logic [GRADE_W-1:0] minGrade,
  output logic [GRADE_W-1:0] maxGrade,
  output logic [GRADE_W-1:0] avgGrade,
  output logic [10:0]        sumGrades,
  output logic               emptyFlag,
  output logic               rangeErr
);

  import grade_pkg::*;

  state_t state, state_next;

  logic [3:0]         n_lat;
  logic [3:0]         idx;
  logic [3:0]         idx_next;
  logic [3:0]         n_clamped;
  logic [GRADE_W-1:0] min_acc;
  logic [GRADE_W-1:0] max_acc;
  logic [SUM_W-1:0]   sum_acc;
  logic               range_acc;
  logic               last_grade;
  logic               div_start;
  logic               div_ready;
  logic [7:0]         div_quotient;

  assign n_clamped  = (gradeCount > 4'(MAX_GRADES)) ? 4'(MAX_GRADES) : gradeCount;
  assign idx_next   = idx + 4'd1;
  assign last_grade = (idx_next == n_lat);
  // The sum is final once the last grade is presented, so the divider can
  // take its first step on the same edge that accepts that grade.
  assign div_start  = (state == PRESENT) && gradeReady && last_grade;

  grade_divider u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_acc),
    .divisor  (n_lat),
    .quotient (div_quotient),
    .ready    (div_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (startReport) state_next = (n_clamped == 4'd0) ? FINISH : READ;
      READ:    state_next = WAIT;
      WAIT:    state_next = PRESENT;
      PRESENT: if (gradeReady) state_next = last_grade ? DIVIDE : READ;
      DIVIDE:  if (div_ready) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so that they line up
  // exactly with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdEn       <= 1'b0;
      rdAddr     <= '0;
      gradeOut   <= '0;
      gradeValid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      minGrade   <= '0;
      maxGrade   <= '0;
      avgGrade   <= '0;
      sumGrades  <= '0;
      emptyFlag  <= 1'b0;
      rangeErr   <= 1'b0;
      n_lat      <= '0;
      idx        <= '0;
      min_acc    <= '1;
      max_acc    <= '0;
      sum_acc    <= '0;
      range_acc  <= 1'b0;
    end else begin
      rdEn       <= (state_next == READ);
      gradeValid <= (state_next == PRESENT);
      busy       <= (state_next != IDLE);
      done       <= (state == FINISH);

      unique case (state)
        IDLE: begin
          if (startReport) begin
            n_lat     <= n_clamped;
            idx       <= '0;
            rdAddr    <= '0;
            min_acc   <= '1;
            max_acc   <= '0;
            sum_acc   <= '0;
            range_acc <= 1'b0;
            minGrade  <= '0;
            maxGrade  <= '0;
            avgGrade  <= '0;
            sumGrades <= '0;
            emptyFlag <= 1'b0;
            rangeErr  <= 1'b0;
          end
        end
        WAIT: begin
          gradeOut <= rdData;
          sum_acc  <= sum_acc + SUM_W'(rdData);
          if (rdData < min_acc) min_acc <= rdData;
          if (rdData > max_acc) max_acc <= rdData;
          if (rdData > GRADE_W'(GRADE_LIMIT)) range_acc <= 1'b1;
        end
        PRESENT: begin
          if (gradeReady && !last_grade) begin
            idx    <= idx_next;
            rdAddr <= idx_next[2:0];
          end
        end
        FINISH: begin
          if (n_lat == 4'd0) begin
            minGrade  <= '0;
            maxGrade  <= '0;
            avgGrade  <= '0;
            sumGrades <= '0;
            emptyFlag <= 1'b1;
            rangeErr  <= 1'b0;
          end else begin
            minGrade  <= min_acc;
            maxGrade  <= max_acc;
            avgGrade  <= GRADE_W'(div_quotient);
            sumGrades <= sum_acc;
            emptyFlag <= 1'b0;
            rangeErr  <= range_acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : grade_reporter

// File: tb/tb_grade_reporter.sv
// ---------------------------------------------------------------------------
// tb_grade_reporter
// Directed bench for grade_reporter: a synchronous storage model answers
// reads, a negedge monitor counts read strobes, done pulses and accepted
// grades, and directed tests compare against hand-computed summaries.
// ---------------------------------------------------------------------------
module tb_grade_reporter;

  logic        clk;
  logic        rst_n;
  logic        startReport;
  logic [3:0]  gradeCount;
  logic        rdEn;
  logic [2:0]  rdAddr;
  logic [7:0]  rdData;
  logic [7:0]  gradeOut;
  logic        gradeValid;
  logic        gradeReady;
  logic        busy;
  logic        done;
  logic [7:0]  minGrade;
  logic [7:0]  maxGrade;
  logic [7:0]  avgGrade;
  logic [10:0] sumGrades;
  logic        emptyFlag;
  logic        rangeErr;

  logic [7:0]  mem [0:7];
  logic [7:0]  grades [$];
  int          rd_count   = 0;
  int          done_count = 0;
  int          viol_count = 0;
  int          checks     = 0;
  int          failures   = 0;
  int          rd0, dn0, q0;

  grade_reporter #(.MAX_GRADES(8), .GRADE_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .startReport (startReport),
    .gradeCount  (gradeCount),
    .rdEn        (rdEn),
    .rdAddr      (rdAddr),
    .rdData      (rdData),
    .gradeOut    (gradeOut),
    .gradeValid  (gradeValid),
    .gradeReady  (gradeReady),
    .busy        (busy),
    .done        (done),
    .minGrade    (minGrade),
    .maxGrade    (maxGrade),
    .avgGrade    (avgGrade),
    .sumGrades   (sumGrades),
    .emptyFlag   (emptyFlag),
    .rangeErr    (rangeErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous storage: data appears one cycle after the read strobe.
  always @(posedge clk) if (rdEn) rdData <= mem[rdAddr];

  always @(negedge clk) begin
    if (rdEn) rd_count <= rd_count + 1;
    if (done) done_count <= done_count + 1;
    if (gradeValid && gradeReady) grades.push_back(gradeOut);
    if (gradeValid && rdEn) viol_count <= viol_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    rd0 = rd_count;
    dn0 = done_count;
    q0  = grades.size();
  endtask

  // Leaves the bench 1 time unit after the edge that sampled startReport.
  task automatic start_report();
    tick();
    startReport = 1'b1;
    tick();
    startReport = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

  task automatic finish_report(input string tag, input int n_exp, input int sum_e,
                               input int min_e, input int max_e, input int avg_e,
                               input logic rng_e);
    wait_done(tag, 200);
    check({tag, "_sum"},   sumGrades, sum_e);
    check({tag, "_min"},   minGrade,  min_e);
    check({tag, "_max"},   maxGrade,  max_e);
    check({tag, "_avg"},   avgGrade,  avg_e);
    check({tag, "_empty"}, emptyFlag, 0);
    check({tag, "_range"}, rangeErr,  rng_e);
    tick();
    check({tag, "_done_width"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_reads"},      rd_count - rd0, n_exp);
    check({tag, "_done_count"}, done_count - dn0, 1);
    check({tag, "_accepted"},   grades.size() - q0, n_exp);
    for (int i = 0; i < n_exp && q0 + i < grades.size(); i++)
      check({tag, "_grade"}, grades[q0 + i], mem[i]);
    tick();
    check({tag, "_stats_hold"}, sumGrades, sum_e);
  endtask

  task automatic load3();
    for (int i = 0; i < 8; i++) mem[i] = 8'd0;
    mem[0] = 8'd56;
    mem[1] = 8'd75;
    mem[2] = 8'd100;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    startReport = 1'b0;
    gradeCount  = 4'd0;
    gradeReady  = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'd0;
    repeat (3) tick();

    // Reset state
    check("rst_rdEn",   rdEn, 0);
    check("rst_valid",  gradeValid, 0);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_empty",  emptyFlag, 0);
    check("rst_range",  rangeErr, 0);
    check("rst_gout",   gradeOut, 0);
    check("rst_addr",   rdAddr, 0);
    check("rst_min",    minGrade, 0);
    check("rst_max",    maxGrade, 0);
    check("rst_avg",    avgGrade, 0);
    check("rst_sum",    sumGrades, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Three grades, ready held high; check first-grade latency
    load3();
    gradeCount = 4'd3;
    gradeReady = 1'b1;
    snap();
    start_report();
    check("basic_busy",    busy, 1);
    check("basic_rdEn",    rdEn, 1);
    check("basic_rdAddr",  rdAddr, 0);
    tick();
    check("basic_rdEn_1cyc", rdEn, 0);
    check("basic_valid_early", gradeValid, 0);
    tick();
    check("basic_valid_lat", gradeValid, 1);
    check("basic_gout0",     gradeOut, 56);
    tick();
    check("basic_valid_drop", gradeValid, 0);
    tick();
    check("basic_rdAddr1",   rdAddr, 1);
    finish_report("basic", 3, 231, 56, 100, 77, 1'b0);

    // Zero grades
    gradeCount = 4'd0;
    snap();
    start_report();
    check("empty_done_early", done, 0);
    check("empty_busy",       busy, 1);
    tick();
    check("empty_done",  done, 1);
    check("empty_flag",  emptyFlag, 1);
    check("empty_sum",   sumGrades, 0);
    check("empty_min",   minGrade, 0);
    check("empty_max",   maxGrade, 0);
    check("empty_avg",   avgGrade, 0);
    tick();
    check("empty_done_width", done, 0);
    check("empty_reads", rd_count - rd0, 0);
    check("empty_accepted", grades.size() - q0, 0);

    // Stall on the second grade for three cycles
    gradeCount = 4'd3;
    snap();
    start_report();
    begin
      int n = 0;
      while (!(gradeValid === 1'b1 && gradeOut === 8'd75) && n < 50) begin
        tick();
        n++;
      end
    end
    check("stall_reach", gradeOut, 75);
    gradeReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", gradeValid, 1);
      check("stall_gout",  gradeOut, 75);
      check("stall_rdEn",  rdEn, 0);
    end
    gradeReady = 1'b1;
    finish_report("stall", 3, 231, 56, 100, 77, 1'b0);

    // Clamp: 12 requested, 8 slots of 255
    for (int i = 0; i < 8; i++) mem[i] = 8'd255;
    gradeCount = 4'd12;
    snap();
    start_report();
    finish_report("clamp", 8, 2040, 255, 255, 255, 1'b1);

    // Start pulsed while busy must be ignored
    load3();
    gradeCount = 4'd3;
    snap();
    start_report();
    repeat (4) tick();
    startReport = 1'b1;
    tick();
    startReport = 1'b0;
    finish_report("ignore", 3, 231, 56, 100, 77, 1'b0);
    repeat (30) tick();
    check("ignore_single_done", done_count - dn0, 1);
    check("ignore_idle", busy, 0);

    // Asynchronous reset while presenting grade 2
    snap();
    start_report();
    begin
      int n = 0;
      while (!(gradeValid === 1'b1 && gradeOut === 8'd75) && n < 50) begin
        tick();
        n++;
      end
    end
    check("arst_reach", gradeOut, 75);
    gradeReady = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rdEn",  rdEn, 0);
    check("arst_valid", gradeValid, 0);
    check("arst_busy",  busy, 0);
    check("arst_done",  done, 0);
    check("arst_gout",  gradeOut, 0);
    check("arst_addr",  rdAddr, 0);
    check("arst_stats", {minGrade, maxGrade, avgGrade}, 0);
    check("arst_sum",   sumGrades, 0);
    check("arst_flags", {emptyFlag, rangeErr}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    gradeReady = 1'b1;
    repeat (30) tick();
    check("arst_no_done", done_count - dn0, 0);
    check("arst_idle",    busy, 0);

    // Fresh report after reset with a different pattern
    mem[0] = 8'd90;
    mem[1] = 8'd10;
    mem[2] = 8'd45;
    mem[3] = 8'd101;
    gradeCount = 4'd4;
    snap();
    start_report();
    finish_report("post_rst", 4, 246, 10, 101, 61, 1'b1);

    check("protocol_valid_rdEn_overlap", viol_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_grade_reporter
